// File: rtl/ipv4_local_lut_pipelined.sv
// IPv4 local-address lookup table for the output-port decision.
// A register-side req/ack port reads and writes ROWS entries of {addr, valid}.
// Destination addresses are matched against every entry in a two-stage
// pipeline. Results {is_local, lowest hit row} go into a fallthrough FIFO.
// Credit-based flow control keeps the FIFO from overflowing.

module ipv4_local_lut_pipelined #(
    parameter int ROWS            = 32,
    parameter int ROW_BITS        = 5,
    parameter int GROUP_SIZE      = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int MATCH_BCAST     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_lut_rd_req,
    output logic                o_lut_rd_ack,
    input  logic [ROW_BITS-1:0] i_lut_rd_addr,
    output logic [31:0]         o_lut_rd_ipv4_addr,
    output logic                o_lut_rd_entry_valid,
    input  logic                i_lut_wr_req,
    output logic                o_lut_wr_ack,
    input  logic [ROW_BITS-1:0] i_lut_wr_addr,
    input  logic [31:0]         i_lut_wr_ipv4_addr,
    input  logic                i_lut_wr_entry_valid,
    input  logic [31:0]         i_daddr,
    input  logic                i_daddr_valid,
    output logic                o_daddr_ready,
    input  logic                i_rd_from_magic,
    output logic                o_is_local,
    output logic [ROW_BITS-1:0] o_hit_idx,
    output logic                o_result_valid,
    output logic [15:0]         o_drop_cnt
);

    localparam int          GROUPS     = (ROWS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int          HIT_BITS   = GROUPS * GROUP_SIZE;
    localparam int          FIFO_DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam logic [31:0] BCAST_ADDR = 32'hFFFF_FFFF;

    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE   = FIFO_DEPTH_BITS'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   COUNT_ONE = (FIFO_DEPTH_BITS + 1)'(1);

    typedef struct packed {
        logic                is_local;
        logic [ROW_BITS-1:0] hit_idx;
    } result_t;

    // ------------------------------------------------------------------
    // Table storage and register port
    // ------------------------------------------------------------------
    logic [31:0]     tbl_addr [ROWS];
    logic [ROWS-1:0] tbl_valid;

    logic rd_serve;
    logic wr_serve;
    logic rd_done;
    logic wr_done;

    // A held request is served once; a read wins over a simultaneous write,
    // which stays pending until the requester sees its ack.
    assign rd_serve = i_lut_rd_req & ~rd_done;
    assign wr_serve = i_lut_wr_req & ~wr_done & ~rd_serve;

    // Ack pulses and per-request "already served" flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_lut_rd_ack <= 1'b0;
            o_lut_wr_ack <= 1'b0;
            rd_done      <= 1'b0;
            wr_done      <= 1'b0;
        end else begin
            o_lut_rd_ack <= rd_serve;
            o_lut_wr_ack <= wr_serve;
            rd_done      <= i_lut_rd_req;
            wr_done      <= i_lut_wr_req & (wr_done | wr_serve);
        end
    end

    logic [31:0] rd_addr_mux;
    logic        rd_valid_mux;

    // Read mux; rows at or beyond ROWS read back as 0/0.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rd_addr_mux  = '0;
        rd_valid_mux = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (i_lut_rd_addr == ROW_BITS'(r)) begin
                rd_addr_mux  = tbl_addr[r];
                rd_valid_mux = tbl_valid[r];
            end
        end
    end

    // Registered read data, updated only when a read is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_lut_rd_ipv4_addr   <= '0;
            o_lut_rd_entry_valid <= 1'b0;
        end else if (rd_serve) begin
            o_lut_rd_ipv4_addr   <= rd_addr_mux;
            o_lut_rd_entry_valid <= rd_valid_mux;
        end
    end

    // Table write; out-of-range rows match no entry and are silently dropped.
    // NOTE: the table is reset because a cleared row must never match; FIFO storage below is not, its output is gated by the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                tbl_addr[r] <= '0;
            end
            tbl_valid <= '0;
        end else if (wr_serve) begin
            for (int r = 0; r < ROWS; r++) begin
                if (i_lut_wr_addr == ROW_BITS'(r)) begin
                    tbl_addr[r]  <= i_lut_wr_ipv4_addr;
                    tbl_valid[r] <= i_lut_wr_entry_valid;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-group compare, padding rows forced to 0
    // ------------------------------------------------------------------
    logic [HIT_BITS-1:0] hit_comb;

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_row
            localparam int ROW = g * GROUP_SIZE + k;
            if (ROW < ROWS) begin : g_live
                assign hit_comb[ROW] = tbl_valid[ROW] & (tbl_addr[ROW] == i_daddr);
            end else begin : g_pad
                assign hit_comb[ROW] = 1'b0;
            end
        end
    end

    logic                accept;
    logic                s1_valid;
    logic [HIT_BITS-1:0] s1_hits;
    logic                s1_bcast;

    assign accept = i_daddr_valid & o_daddr_ready;

    // Stage-1 register: hit vector plus broadcast flag of the accepted lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_hits  <= '0;
            s1_bcast <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_hits  <= hit_comb;
                s1_bcast <= (MATCH_BCAST != 0) && (i_daddr == BCAST_ADDR);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduce and priority-encode; the result is written straight
    // into FIFO storage, so the FIFO entry is the stage-2 register and its
    // credit is carried by fifo_count.
    // ------------------------------------------------------------------
    result_t s2_result;

    // Lowest matching row wins; broadcast overrides to row 0.
    always_comb begin
        s2_result          = '0;
        s2_result.is_local = (|s1_hits) | s1_bcast;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (s1_hits[r]) begin
                s2_result.hit_idx = ROW_BITS'(r);
            end
        end
        if (s1_bcast) begin
            s2_result.hit_idx = '0;
        end
    end

    // ------------------------------------------------------------------
    // Fallthrough result FIFO and credit accounting
    // ------------------------------------------------------------------
    result_t                    fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   fifo_count;
    logic                       push;
    logic                       pop;
    result_t                    head;
    logic [FIFO_DEPTH_BITS+1:0] occupancy;

    assign push = s1_valid;
    assign pop  = i_rd_from_magic & (fifo_count != '0);

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s2_result;
        end
    end

    // FIFO pointers and occupancy count; push+pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Ready depends only on registered state, so a pop frees its credit a cycle later.
    assign occupancy     = {1'b0, fifo_count} + {{(FIFO_DEPTH_BITS + 1){1'b0}}, s1_valid};
    assign o_daddr_ready = occupancy < (FIFO_DEPTH_BITS + 2)'(FIFO_DEPTH);

    assign head           = fifo_mem[rd_ptr];
    assign o_result_valid = (fifo_count != '0);
    assign o_is_local     = o_result_valid & head.is_local;
    assign o_hit_idx      = o_result_valid ? head.hit_idx : '0;

    // Saturating count of lookups presented while no credit was available.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_drop_cnt <= '0;
        end else if (i_daddr_valid && !o_daddr_ready && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule
